// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// The IDLE -> EXEC -> RESP sequence captures the winning request's operands
// into registers that drive the ALU. It then samples the ALU result and zero
// flag, and returns them over a valid/ready handshake to the granted requester.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie
// (fixed priority). When undefined, ties alternate round-robin.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*OP_WIDTH-1:0]   req_op_i,
  input  logic [2*DATA_WIDTH-1:0] req_a_i,
  input  logic [2*DATA_WIDTH-1:0] req_b_i,
  input  logic [9:0]              req_shamt_i,
  input  logic [31:0]             req_imm_i,
  output logic [1:0]              rsp_valid_o,
  input  logic [1:0]              rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_zero_o,
  output logic                    busy_o,
  output logic [OP_WIDTH-1:0]     alu_operation_o,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  output logic [4:0]              alu_shamt_o,
  output logic [15:0]             alu_imm_o,
  input  logic [DATA_WIDTH-1:0]   alu_data_i,
  input  logic                    alu_zero_i
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;
  logic   grant_q;
  logic   winner;
  logic   accept;
  logic   rsp_done;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   last_grant_q;
`endif

  // Operand fields of the current arbitration winner.
  logic [OP_WIDTH-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [4:0]            shamt_sel;
  logic [15:0]           imm_sel;

  assign op_sel    = winner ? req_op_i[2*OP_WIDTH-1:OP_WIDTH]     : req_op_i[OP_WIDTH-1:0];
  assign a_sel     = winner ? req_a_i[2*DATA_WIDTH-1:DATA_WIDTH]  : req_a_i[DATA_WIDTH-1:0];
  assign b_sel     = winner ? req_b_i[2*DATA_WIDTH-1:DATA_WIDTH]  : req_b_i[DATA_WIDTH-1:0];
  assign shamt_sel = winner ? req_shamt_i[9:5]                    : req_shamt_i[4:0];
  assign imm_sel   = winner ? req_imm_i[31:16]                    : req_imm_i[15:0];

  // The response completes only on the granted requester's ready; the other ready is ignored.
  assign rsp_done = (state_q == RESP) && rsp_ready_i[grant_q];

  // Winner selection: a lone valid requester wins; a tie goes by priority policy.
  always_comb begin
    winner = req_valid_i[1] & ~req_valid_i[0];
    if (&req_valid_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant_q;
`endif
    end
  end

  // Next-state logic and the combinational request accept.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 2'b00;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          accept      = 1'b1;
          req_ready_o = winner ? 2'b10 : 2'b01;
          state_d     = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Control: grant bookkeeping, response valid and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
      rsp_valid_o  <= 2'b00;
      busy_o       <= 1'b0;
    end else begin
      busy_o <= (state_d != IDLE);
      if (accept) grant_q <= winner;
      if (state_q == EXEC) rsp_valid_o <= grant_q ? 2'b10 : 2'b01;
      if (rsp_done) begin
        rsp_valid_o  <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_q <= grant_q;
`endif
      end
    end
  end

  // Data: ALU operand registers and the sampled ALU result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_operation_o <= '0;
      alu_a_o         <= '0;
      alu_b_o         <= '0;
      alu_shamt_o     <= '0;
      alu_imm_o       <= '0;
      rsp_data_o      <= '0;
      rsp_zero_o      <= 1'b0;
    end else begin
      if (accept) begin
        alu_operation_o <= op_sel;
        alu_a_o         <= a_sel;
        alu_b_o         <= b_sel;
        alu_shamt_o     <= shamt_sel;
        alu_imm_o       <= imm_sel;
      end else if (rsp_done) begin
        alu_operation_o <= '0;
        alu_a_o         <= '0;
        alu_b_o         <= '0;
        alu_shamt_o     <= '0;
        alu_imm_o       <= '0;
      end
      if (state_q == EXEC) begin
        rsp_data_o <= alu_data_i;
        rsp_zero_o <= alu_zero_i;
      end
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters, e.g. a main execute path and an address/branch helper.
- Arbitrates, captures the winning operands and drives the ALU's operation/operand inputs from registers.
- Samples the ALU result and zero flag, and returns them to the granted requester over a valid/ready handshake.
- Sits between the requester logic and the ALU; does not decode or interpret opcodes.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OP_WIDTH, 4, ALU operation code width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid_i  input  2  per-requester request valid; bit n = requester n.
- req_ready_o  output  2  per-requester request accept.
- req_op_i  input  2*OP_WIDTH  packed ops {req1,req0}.
- req_a_i  input  2*DATA_WIDTH  packed operand A {req1,req0}.
- req_b_i  input  2*DATA_WIDTH  packed operand B {req1,req0}.
- req_shamt_i  input  10  packed shift amounts {req1,req0}.
- req_imm_i  input  32  packed 16-bit immediates {req1,req0}.
- rsp_valid_o  output  2  response valid; only the granted bit can be set.
- rsp_ready_i  input  2  per-requester response accept.
- rsp_data_o  output  DATA_WIDTH  registered ALU result.
- rsp_zero_o  output  1  registered ALU zero flag.
- busy_o  output  1  high in EXEC and RESP.
- alu_operation_o  output  OP_WIDTH  to ALU operation input.
- alu_a_o  output  DATA_WIDTH  to ALU operand A.
- alu_b_o  output  DATA_WIDTH  to ALU operand B.
- alu_shamt_o  output  5  to ALU shift amount.
- alu_imm_o  output  16  to ALU immediate.
- alu_data_i  input  DATA_WIDTH  ALU result (combinational).
- alu_zero_i  input  1  ALU zero flag (combinational).

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, last_grant=1, grant=0.
  - All registered outputs 0: alu_*_o, rsp_data_o, rsp_zero_o, rsp_valid_o, busy_o.
- Reset mid-operation aborts the transaction; no response is ever issued for it.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if req_valid_i!=0, pick winner g and assert req_ready_o[g] combinationally in the same cycle. On that edge, capture op/a/b/shamt/imm of g into the alu_*_o registers, set grant=g, go EXEC. Otherwise stay IDLE with alu_*_o=0.
  - EXEC: alu_*_o held; at the edge capture alu_data_i into rsp_data_o and alu_zero_i into rsp_zero_o, go RESP.
  - RESP: rsp_valid_o[grant]=1, rsp_data_o/rsp_zero_o/alu_*_o held. When rsp_ready_i[grant]=1: clear rsp_valid_o, set last_grant=grant, clear alu_*_o to 0, go IDLE. rsp_ready_i of the non-granted requester is ignored.
- Latency and throughput:
  - Request handshake to rsp_valid_o = 2 cycles.
  - Minimum 3 cycles per op; no back-to-back acceptance.
- Handshake rules:
  - req_ready_o=0 in EXEC and RESP regardless of req_valid_i.
  - Requesters must hold valid and operands stable until ready.
  - Valid deasserted before ready is legal; nothing is captured.
- Arbitration (default round-robin):
  - Single valid requester: it wins.
  - Both valid: winner = ~last_grant.
  - After reset, requester 0 wins the first tie.
- Operation codes are forwarded unmodified. Codes the ALU does not implement return 0 with zero=1; this is not an error.
- Shift amounts and immediates are sliced from their packed buses: req n uses bits [5n+4:5n] and [16n+15:16n].

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins a tie, and last_grant is neither used nor updated.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single request: req0 op=ADD(0), a=5, b=7 held valid from cycle 0 -> req_ready_o=01 in cycle 0; rsp_valid_o=01 from cycle 2; rsp_data_o=12, rsp_zero_o=0.
- Zero flag: req1 op=SUB(1), a=b=32'h1234 -> rsp_valid_o=10, rsp_data_o=0, rsp_zero_o=1.
- Tie, round-robin: both valid continuously, rsp_ready_i=11 -> grants alternate 0,1,0,1; each op takes 3 cycles; with ALU_ARB_FIXED_PRIO_EN defined, all four grants go to 0.
- Backpressure: req0 LUI(6) imm=16'hABCD with rsp_ready_i=00 for 5 cycles -> rsp_valid_o=01 and rsp_data_o=32'hABCD0000 held stable; req_ready_o[1] stays 0 despite req1 valid; IDLE one cycle after rsp_ready_i[0]=1.
- Reset mid-op: drop reset in EXEC -> all outputs 0 immediately (asynchronous); after release, no rsp_valid_o for the aborted op, and a tied request is granted to req0.
- Shift slicing: req1 SLL(5), b=1, req_shamt_i=10'b00011_00000 -> alu_shamt_o=3, rsp_data_o=8.
